result_uart_tx: RTL and testbench

- Consumer end of the averager result interface.
- Captures the N-bit averaged temperature result on its single-cycle ready strobe and serializes it off-chip as 8N1 UART frames, least significant byte first.
- Sits between the averaging block and a single output pin. Gives the host a framed, self-timed readout of each measurement window.

---
 rtl/result_tx_pkg.sv | 23 ++
 rtl/result_uart_tx_baud_gen.sv | 22 ++
 rtl/result_uart_tx.sv | 146 ++++++++++++++
 tb/tb_result_uart_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result UART transmitter.
// RESULT_TX_PARITY_EN adds an even-parity bit after the data bits.
package result_tx_pkg;

    localparam int DATA_BITS = 8;
`ifdef RESULT_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

`ifdef RESULT_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // Number of bytes needed to carry an n-bit result.
    function automatic int byte_count(input int n);
        return (n + DATA_BITS - 1) / DATA_BITS;
    endfunction

endpackage

// File: rtl/result_uart_tx_baud_gen.sv
// Bit-period timer: wraps every CLKS_PER_BIT cycles, restarts on clear.
module tx_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 cnt <= '0;
        else if (clear || bit_tick) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/result_uart_tx.sv
// Serializes each averaged result as 8N1 UART frames, LSB byte first.
// Define RESULT_TX_PARITY_EN for an even-parity bit before each stop bit.
module result_uart_tx
    import result_tx_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic         overrun
);
    localparam int BYTES = byte_count(N);
    localparam int SW    = BYTES * DATA_BITS;

    state_t        state, nxt;
    logic [SW-1:0] shreg, shreg_n;
    logic [2:0]    bit_idx, bit_n;
    logic [1:0]    byte_idx, byte_n;
    logic          tx_n, busy_n, done_n, ovr_n;
    logic          bit_tick, clear;
`ifdef RESULT_TX_PARITY_EN
    logic          par, par_n;
`endif

    // Restart the bit timer on every state entry and hold it while idle.
    assign clear = (nxt != state) || (state == IDLE);

    tx_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
`ifdef RESULT_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= nxt;
            shreg    <= shreg_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
            overrun  <= ovr_n;
`ifdef RESULT_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    always_comb begin
        nxt     = state;
        shreg_n = shreg;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        done_n  = 1'b0;
`ifdef RESULT_TX_PARITY_EN
        par_n   = par;
`endif
        // The done cycle is already IDLE but still refuses new data.
        ovr_n   = overrun | (data_valid & ((state != IDLE) | done));

        case (state)
            IDLE: if (en && data_valid && !done) begin
                nxt            = START;
                shreg_n        = '0;
                shreg_n[N-1:0] = data_in;
                bit_n          = '0;
                byte_n         = '0;
            end
            START: if (bit_tick) begin
                nxt   = DATA;
                bit_n = '0;
`ifdef RESULT_TX_PARITY_EN
                par_n = 1'b0;
`endif
            end
            DATA: if (bit_tick) begin
`ifdef RESULT_TX_PARITY_EN
                par_n = par ^ shreg[0];
`endif
                shreg_n = shreg >> 1;
                if (bit_idx == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
                    nxt = PARITY;
`else
                    nxt = STOP;
`endif
                end else begin
                    bit_n = bit_idx + 3'd1;
                end
            end
`ifdef RESULT_TX_PARITY_EN
            PARITY: if (bit_tick) nxt = STOP;
`endif
            STOP: if (bit_tick) begin
                if (byte_idx != 2'(BYTES - 1)) begin
                    byte_n = byte_idx + 2'd1;
                    nxt    = START;
                end else begin
                    nxt    = IDLE;
                    done_n = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase

        if (!en) begin
            nxt     = IDLE;
            shreg_n = '0;
            bit_n   = '0;
            byte_n  = '0;
            done_n  = 1'b0;
        end

        busy_n = (nxt != IDLE);
        case (nxt)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
`ifdef RESULT_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: N=8 and N=16 instances, CLKS_PER_BIT=4.
module tb_result_uart_tx;
    localparam int CPB = 4;
`ifdef RESULT_TX_PARITY_EN
    localparam int FR = 11;
`else
    localparam int FR = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  din8 = '0;
    logic [15:0] din16 = '0;
    logic        dv8 = 1'b0, dv16 = 1'b0;
    logic        tx8, busy8, done8, ovr8;
    logic        tx16, busy16, done16, ovr16;
    int          ncmp = 0, nerr = 0;

    always #5 clk = ~clk;

    result_uart_tx #(.N(8), .CLKS_PER_BIT(CPB)) dut8 (
        .clk(clk), .reset(rst_n), .en(en), .data_in(din8), .data_valid(dv8),
        .tx(tx8), .busy(busy8), .done(done8), .overrun(ovr8)
    );

    result_uart_tx #(.N(16), .CLKS_PER_BIT(CPB)) dut16 (
        .clk(clk), .reset(rst_n), .en(en), .data_in(din16), .data_valid(dv16),
        .tx(tx16), .busy(busy16), .done(done16), .overrun(ovr16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit k of the frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef RESULT_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // One N=8 transfer. pulse_at: extra strobe cycle; abort_at: en drops that cycle;
    // strobe_done: strobe again on the done cycle.
    task automatic run8(input logic [7:0] d, input int pulse_at, input int abort_at,
                        input bit strobe_done, input logic exp_ovr);
        din8 = d; dv8 = 1'b1; en = 1'b1;
        step();
        dv8 = 1'b0;
        for (int c = 1; c <= FR * CPB; c++) begin
            dv8 = (c == pulse_at);
            if (abort_at > 0 && c >= abort_at) en = 1'b0;
            if (abort_at > 0 && c > abort_at) begin
                chk("abort_tx", 16'(tx8), 16'd1);
                chk("abort_busy", 16'(busy8), 16'd0);
                chk("abort_done", 16'(done8), 16'd0);
                if (c >= abort_at + 4) break;
            end else begin
                chk("frame_tx", 16'(tx8), 16'(frame_bit(d, (c - 1) / CPB)));
                chk("frame_busy", 16'(busy8), 16'd1);
                chk("frame_done", 16'(done8), 16'd0);
            end
            step();
        end
        dv8 = 1'b0;
        if (abort_at > 0) begin
            en = 1'b1;
            step();
            chk("abort_idle_busy", 16'(busy8), 16'd0);
        end else begin
            chk("end_done", 16'(done8), 16'd1);
            chk("end_busy", 16'(busy8), 16'd0);
            chk("end_tx", 16'(tx8), 16'd1);
            dv8 = strobe_done;
            step();
            dv8 = 1'b0;
            chk("post_done", 16'(done8), 16'd0);
            chk("post_busy", 16'(busy8), 16'd0);
            chk("post_tx", 16'(tx8), 16'd1);
        end
        chk("overrun", 16'(ovr8), 16'(exp_ovr));
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_tx8", 16'(tx8), 16'd1);
        chk("rst_busy8", 16'(busy8), 16'd0);
        chk("rst_done8", 16'(done8), 16'd0);
        chk("rst_ovr8", 16'(ovr8), 16'd0);
        chk("rst_tx16", 16'(tx16), 16'd1);
        rst_n = 1'b1;
        step();

        // strobe with en low is ignored
        dv8 = 1'b1; din8 = 8'hFF;
        step();
        dv8 = 1'b0;
        chk("en_low_busy", 16'(busy8), 16'd0);
        chk("en_low_ovr", 16'(ovr8), 16'd0);

        run8(8'hA5, 0, 0, 1'b0, 1'b0);
        run8(8'h01, 0, 0, 1'b0, 1'b0);

        // N=16: 0x34 frame then 0x12 frame, no gap
        din16 = 16'h1234; dv16 = 1'b1;
        step();
        dv16 = 1'b0;
        for (int c = 1; c <= 2 * FR * CPB; c++) begin
            chk("w16_tx", 16'(tx16),
                16'(frame_bit((c <= FR * CPB) ? 8'h34 : 8'h12, ((c - 1) % (FR * CPB)) / CPB)));
            chk("w16_busy", 16'(busy16), 16'd1);
            step();
        end
        chk("w16_done", 16'(done16), 16'd1);
        chk("w16_end_busy", 16'(busy16), 16'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("w16_idle_tx", 16'(tx16), 16'd1);
            chk("w16_idle_done", 16'(done16), 16'd0);
        end

        // overrun mid-frame and on the done cycle; waveform unchanged
        run8(8'hA5, 10, 0, 1'b1, 1'b1);
        chk("ovr_no_restart", 16'(busy8), 16'd0);

        // abort then a clean frame
        run8(8'hC3, 0, 15, 1'b0, 1'b1);
        run8(8'h5A, 0, 0, 1'b0, 1'b1);

        // async reset mid-DATA, off the clock edge
        din8 = 8'h77; dv8 = 1'b1;
        step();
        dv8 = 1'b0;
        for (int c = 0; c < 18; c++) step();
        chk("pre_rst_busy", 16'(busy8), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", 16'(tx8), 16'd1);
        chk("arst_busy", 16'(busy8), 16'd0);
        chk("arst_ovr", 16'(ovr8), 16'd0);
        step();
        rst_n = 1'b1;
        step();
        run8(8'h3C, 0, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
